// File: rtl/output_channel_enqueueing_unit.sv
// Per-channel output FIFOs fed from PE writeback under the OCE mask; each channel
// exposes a valid/ready producer port and a full flag used as backpressure.
module output_channel_enqueueing_unit #(
  parameter int NUM_OUTPUT_CHANNELS = 4,
  parameter int DATA_WIDTH          = 32,
  parameter int TAG_WIDTH           = 2,
  parameter int DEPTH               = 2
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      enable,
  input  logic [NUM_OUTPUT_CHANNELS-1:0]            oce,
  input  logic [DATA_WIDTH-1:0]                     data,
  input  logic [TAG_WIDTH-1:0]                      tag,
  output logic [NUM_OUTPUT_CHANNELS-1:0]            full,
  output logic [NUM_OUTPUT_CHANNELS-1:0]            out_valid,
  output logic [NUM_OUTPUT_CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic [NUM_OUTPUT_CHANNELS*TAG_WIDTH-1:0]  out_tag,
  input  logic [NUM_OUTPUT_CHANNELS-1:0]            out_ready,
  output logic                                      overflow_error
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = TAG_WIDTH + DATA_WIDTH;

  logic [NUM_OUTPUT_CHANNELS-1:0] ovf;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  for (genvar i = 0; i < NUM_OUTPUT_CHANNELS; i++) begin : g_ch
    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          enq;
    logic          deq;
    logic          accept;
    logic          is_full;

    assign is_full = (count == CW'(DEPTH));
    assign enq     = enable & oce[i];
    assign deq     = (count != '0) & out_ready[i];
    // A full channel still accepts when its head leaves in the same cycle.
    assign accept  = enq & (~is_full | deq);
    assign ovf[i]  = enq & is_full & ~deq;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (deq)    rd_ptr <= ptr_next(rd_ptr);
        if (accept) wr_ptr <= ptr_next(wr_ptr);
        if (accept && !deq)      count <= count + CW'(1);
        else if (deq && !accept) count <= count - CW'(1);
      end
    end

    // Storage contents are don't-care after reset, so no reset branch here.
    always_ff @(posedge clock) begin
      if (accept) mem[wr_ptr] <= {tag, data};
    end

    assign full[i]      = is_full;
    assign out_valid[i] = (count != '0);
    assign {out_tag[i*TAG_WIDTH +: TAG_WIDTH], out_data[i*DATA_WIDTH +: DATA_WIDTH]} = mem[rd_ptr];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)     overflow_error <= 1'b0;
    else if (|ovf) overflow_error <= 1'b1;
  end

endmodule

// File: tb/tb_output_channel_enqueueing_unit.sv
// Randomized and directed checks of the output-channel enqueueing unit against
// a queue-based model of the per-channel FIFOs.
module tb_output_channel_enqueueing_unit;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TW = 2;
  localparam int D  = 2;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            enable = 1'b0;
  logic [N-1:0]    oce = '0;
  logic [DW-1:0]   data = '0;
  logic [TW-1:0]   tag = '0;
  logic [N-1:0]    full;
  logic [N-1:0]    out_valid;
  logic [N*DW-1:0] out_data;
  logic [N*TW-1:0] out_tag;
  logic [N-1:0]    out_ready = '0;
  logic            overflow_error;

  output_channel_enqueueing_unit #(
    .NUM_OUTPUT_CHANNELS(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(D)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .oce(oce), .data(data),
    .tag(tag), .full(full), .out_valid(out_valid), .out_data(out_data),
    .out_tag(out_tag), .out_ready(out_ready), .overflow_error(overflow_error)
  );

  always #5 clock = ~clock;

  logic [TW+DW-1:0] mq [N][$];
  logic             m_ovf = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] hd(input int i);
    return out_data[i*DW +: DW];
  endfunction

  function automatic logic [TW-1:0] ht(input int i);
    return out_tag[i*TW +: TW];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) mq[i].delete();
    m_ovf = 1'b0;
  endtask

  // Applied at each rising edge with the inputs that were stable across it.
  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      bit dq, eq;
      dq = (mq[i].size() != 0) && out_ready[i];
      eq = enable && oce[i];
      if (eq && mq[i].size() == D && !dq) m_ovf = 1'b1;
      else begin
        if (dq) void'(mq[i].pop_front());
        if (eq) mq[i].push_back({tag, data});
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("valid[%0d]", i), 64'(out_valid[i]), 64'(mq[i].size() != 0));
      chk($sformatf("full[%0d]", i), 64'(full[i]), 64'(mq[i].size() == D));
      if (mq[i].size() != 0) begin
        chk($sformatf("data[%0d]", i), 64'(hd(i)), 64'(mq[i][0][DW-1:0]));
        chk($sformatf("tag[%0d]", i), 64'(ht(i)), 64'(mq[i][0][TW+DW-1:DW]));
      end
    end
    chk("overflow_error", 64'(overflow_error), 64'(m_ovf));
  endtask

  task automatic cyc(input logic en, input logic [N-1:0] m, input logic [DW-1:0] d,
                     input logic [TW-1:0] t, input logic [N-1:0] rdy);
    enable = en; oce = m; data = d; tag = t; out_ready = rdy;
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare_all();
  endtask

  task automatic drain_all();
    for (int k = 0; k < D + 1; k++) cyc(1'b0, '0, '0, '0, '1);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst out_valid", 64'(out_valid), 64'(0));
    chk("rst full", 64'(full), 64'(0));
    chk("rst overflow", 64'(overflow_error), 64'(0));
    model_clear();
    @(negedge clock);
    reset = 1'b0;
    enable = 1'b0; oce = '0; out_ready = '0;
    compare_all();
  endtask

  initial begin
    model_clear();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    compare_all();

    // Broadcast to ch0 and ch2 only.
    cyc(1'b1, 4'b0101, 32'hDEAD_BEEF, 2'b10, '0);
    chk("t2 valid", 64'(out_valid), 64'(4'b0101));
    chk("t2 data0", 64'(hd(0)), 64'h0000_0000_DEAD_BEEF);
    chk("t2 data2", 64'(hd(2)), 64'h0000_0000_DEAD_BEEF);
    chk("t2 tag2", 64'(ht(2)), 64'(2'b10));
    drain_all();

    // Fill ch1, then drain in order.
    cyc(1'b1, 4'b0010, 32'h11, 2'b01, '0);
    cyc(1'b1, 4'b0010, 32'h22, 2'b11, '0);
    chk("t3 full1", 64'(full[1]), 64'(1));
    chk("t3 head0", 64'(hd(1)), 64'h11);
    cyc(1'b0, '0, '0, '0, 4'b0010);
    chk("t3 head1", 64'(hd(1)), 64'h22);
    cyc(1'b0, '0, '0, '0, 4'b0010);
    chk("t3 empty", 64'(out_valid[1]), 64'(0));

    // Enqueue into a full channel that is draining the same cycle.
    cyc(1'b1, 4'b0001, 32'hA, 2'b00, '0);
    cyc(1'b1, 4'b0001, 32'hB, 2'b00, '0);
    cyc(1'b1, 4'b0001, 32'hC, 2'b01, 4'b0001);
    chk("t4 full0", 64'(full[0]), 64'(1));
    chk("t4 headB", 64'(hd(0)), 64'hB);
    cyc(1'b0, '0, '0, '0, 4'b0001);
    chk("t4 headC", 64'(hd(0)), 64'hC);
    chk("t4 ovf", 64'(overflow_error), 64'(0));
    drain_all();

    // Wrap: back-to-back enqueue/dequeue on ch2.
    for (int k = 1; k <= 10; k++) begin
      cyc(1'b1, 4'b0100, DW'(k), TW'(k), 4'b0100);
      chk("t6 head", 64'(hd(2)), 64'(k));
      chk("t6 full2", 64'(full[2]), 64'(0));
    end
    chk("t6 ovf", 64'(overflow_error), 64'(0));
    drain_all();

    // Overflow on ch3 while ch1 accepts the same word.
    cyc(1'b1, 4'b1000, 32'h55, 2'b01, '0);
    cyc(1'b1, 4'b1000, 32'h66, 2'b10, '0);
    cyc(1'b1, 4'b1010, 32'h99, 2'b11, '0);
    chk("t5 ovf", 64'(overflow_error), 64'(1));
    chk("t5 ch1 data", 64'(hd(1)), 64'h99);
    chk("t5 ch3 head", 64'(hd(3)), 64'h55);
    cyc(1'b0, '0, '0, '0, 4'b1000);
    chk("t5 ch3 second", 64'(hd(3)), 64'h66);
    cyc(1'b0, '0, '0, '0, 4'b1000);
    chk("t5 ch3 empty", 64'(out_valid[3]), 64'(0));
    chk("t5 ovf sticky", 64'(overflow_error), 64'(1));

    // Async reset with two entries queued.
    cyc(1'b1, 4'b0001, 32'h1, 2'b00, '0);
    cyc(1'b1, 4'b0001, 32'h2, 2'b00, '0);
    do_reset();

    for (int n = 0; n < 3000; n++) begin
      logic [N-1:0] rdy;
      rdy = N'($urandom) | N'($urandom);
      if (n % 500 < 250) rdy = N'($urandom) & N'($urandom);
      cyc(1'($urandom_range(0, 3) != 0), N'($urandom), DW'($urandom), TW'($urandom), rdy);
      if (n == 1500) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
